// File: rtl/byte_serializer_pkg.sv
// Serializer shared package
// Holds the FSM state type, line levels and default parameters.
// The SERIALIZER_PARITY_EN macro adds the PARITY state to the state type.
package serializer_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_BIT_TICKS = 10;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SERIALIZER_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

endpackage

// File: rtl/byte_serializer_if.sv
// Serializer load/line interface
// master: word source (drives load_valid, load_data, dir)
// slave : serializer  (drives load_ready, tx_bit, tx_active, done)
interface byte_serializer_if
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             dir;
   logic             load_ready;
   logic             tx_bit;
   logic             tx_active;
   logic             done;

   modport master (
      output load_valid, load_data, dir,
      input  load_ready, tx_bit, tx_active, done
   );

   modport slave (
      input  load_valid, load_data, dir,
      output load_ready, tx_bit, tx_active, done
   );

endinterface

// File: rtl/byte_serializer_bit_timer.sv
// Bit period timer for the serializer
// Ports: clk, reset (async, high), clear (hold count at 0),
//        tc (one-cycle pulse on the last tick of each bit).
module bit_timer
   import serializer_pkg::*;
#(
   parameter int TICKS = DEF_BIT_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tc
);

   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

   logic [CW-1:0] cnt;
   logic          last;

   assign last = (cnt == CW'(TICKS - 1));
   assign tc   = last & ~clear;

   // Wraps to 0 on terminal count so every bit restarts at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || last)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/byte_serializer.sv
// Byte serializer: START, WIDTH data bits, optional PARITY, STOP.
// Ports: clk, reset (async, high), bus (byte_serializer_if.slave).
// Params: WIDTH (1..15, must match bus), BIT_TICKS (>=1).
// Macro SERIALIZER_PARITY_EN inserts an even-parity bit before STOP.
module byte_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int BIT_TICKS = DEF_BIT_TICKS
) (
   input  logic             clk,
   input  logic             reset,
   byte_serializer_if.slave bus
);

   localparam int BCW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] sh;
   logic             dir_q;
   logic [BCW-1:0]   bit_cnt;
   logic             done_q;
   logic             tc;
   logic             accept;
   logic             last_bit;
   logic             cur_bit;
   logic             tx;
`ifdef SERIALIZER_PARITY_EN
   logic             par_q;
`endif

   assign accept   = bus.load_valid & (state == S_IDLE);
   assign last_bit = (bit_cnt == BCW'(WIDTH - 1));
   // Shift register always presents the next bit at one end.
   assign cur_bit  = dir_q ? sh[0] : sh[WIDTH-1];

   bit_timer #(
      .TICKS (BIT_TICKS)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state == S_IDLE),
      .tc    (tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      tx  = IDLE_LEVEL;
      unique case (state)
         S_IDLE: begin
            if (accept)
               nxt = S_START;
         end
         S_START: begin
            tx = START_LEVEL;
            if (tc)
               nxt = S_DATA;
         end
         S_DATA: begin
            tx = cur_bit;
            if (tc && last_bit)
`ifdef SERIALIZER_PARITY_EN
               nxt = S_PARITY;
`else
               nxt = S_STOP;
`endif
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            tx = par_q;
            if (tc)
               nxt = S_STOP;
         end
`endif
         S_STOP: begin
            tx = STOP_LEVEL;
            if (tc)
               nxt = S_IDLE;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh      <= '0;
         dir_q   <= 1'b0;
         bit_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state == S_STOP) & tc;
         if (accept) begin
            sh      <= bus.load_data;
            dir_q   <= bus.dir;
            bit_cnt <= '0;
         end else if (state == S_DATA && tc) begin
            sh      <= dir_q ? (sh >> 1) : (sh << 1);
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

`ifdef SERIALIZER_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         par_q <= 1'b0;
      else if (accept)
         par_q <= ^bus.load_data;
   end
`endif

   assign bus.load_ready = (state == S_IDLE);
   assign bus.tx_active  = (state != S_IDLE);
   assign bus.tx_bit     = tx;
   assign bus.done       = done_q;

endmodule
